// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle for the shift-and-add multiplier.
// The master drives the request and operands; the slave returns status strobes and the product.
interface seq_multiplier_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             clear;
    logic             load;
    logic             shift;
    logic             ready;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  clear, load, shift, ready, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output clear, load, shift, ready, done, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned N x N shift-and-add multiplier, one ADD/SHIFT pair per multiplier bit.
// state | meaning
// IDLE  | waiting for start, operands captured on start
// INIT  | product register loaded with Qr, counter cleared
// ADD   | add Mr into upper half when P[0] is set
// SHIFT | shift product right, advance bit counter
// DONE  | one-cycle completion pulse, product valid
module seq_multiplier #(
    parameter int N = 8
) (
    input  logic            clock,
    input  logic            n_reset,
    seq_multiplier_if.slave bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    mr;
    logic [N-1:0]    qr;
    logic [2*N:0]    p;
    logic [CW-1:0]   cnt;
    logic            clear_c;
    logic            load_c;
    logic            shift_c;
    logic            ready_c;
    logic            done_c;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            mr  <= '0;
            qr  <= '0;
            p   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mr <= bus.multiplicand;
                        qr <= bus.multiplier;
                    end
                end
                S_INIT: begin
                    p   <= {{(N+1){1'b0}}, qr};
                    cnt <= '0;
                end
                S_ADD: begin
                    // Carry lands in P[2N] and is shifted back into the upper half next cycle
                    if (p[0]) begin
                        p[2*N:N] <= {1'b0, p[2*N-1:N]} + {1'b0, mr};
                    end
                end
                S_SHIFT: begin
                    p   <= p >> 1;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        clear_c   = 1'b0;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        ready_c   = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.start) state_nxt = S_INIT;
            end
            S_INIT: begin
                clear_c   = 1'b1;
                state_nxt = S_ADD;
            end
            S_ADD: begin
                load_c    = p[0];
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                shift_c   = 1'b1;
                state_nxt = (cnt == CNT_LAST) ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.clear   = clear_c;
    assign bus.load    = load_c;
    assign bus.shift   = shift_c;
    assign bus.ready   = ready_c;
    assign bus.done    = done_c;
    assign bus.product = p[2*N-1:0];
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised and directed checks of seq_multiplier against an arithmetic reference:
// product = M*Q, N ADD/SHIFT pairs, popcount(Q) load cycles, fixed start-to-done latency.
module tb_seq_multiplier;
    localparam int N       = 8;
    localparam int LAT     = 2*N + 2;
    localparam int PERIOD  = 2*N + 3;

    logic clock;
    logic n_reset;
    int   n_compared;
    int   n_mismatched;

    seq_multiplier_if #(.N(N)) bus ();

    seq_multiplier #(.N(N)) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        logic [5:0] obs;
        obs = {bus.ready, bus.clear, bus.load, bus.shift, bus.done, 1'b0};
        chk({tag, "_strobes"}, obs, 6'b100000);
        chk({tag, "_product"}, bus.product, 0);
    endtask

    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q, input bit perturb);
        logic [2*N-1:0] exp_p;
        int cyc, n_clr, n_ld, n_sh, done_cyc;
        bit seen, bad;
        exp_p = m * q;
        n_clr = 0; n_ld = 0; n_sh = 0; seen = 0; bad = 0; done_cyc = -1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (!seen && cyc <= 4*N + 10) begin
            if ((int'(bus.clear) + int'(bus.shift) + int'(bus.ready) + int'(bus.done)) > 1) bad = 1;
            if (bus.load && (bus.clear || bus.shift || bus.ready || bus.done)) bad = 1;
            if (bus.ready) bad = 1;
            n_clr += int'(bus.clear);
            n_ld  += int'(bus.load);
            n_sh  += int'(bus.shift);
            if (bus.done) begin
                seen = 1;
                done_cyc = cyc;
                chk("product", bus.product, exp_p);
            end else begin
                if (perturb) begin
                    bus.start        = 1'($urandom);
                    bus.multiplicand = N'($urandom);
                    bus.multiplier   = N'($urandom);
                end
                step();
                cyc++;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", done_cyc, LAT);
        chk("decode_exclusive", bad, 0);
        chk("clear_cycles", n_clr, 1);
        chk("load_cycles", n_ld, $countones(q));
        chk("shift_cycles", n_sh, N);
        step();
        chk("ready_after_done", {bus.ready, bus.done}, 2'b10);
        chk("product_hold", bus.product, exp_p);
    endtask

    initial begin
        int done_cyc[2];
        logic [2*N-1:0] done_p[2];
        int nd, sh, dones, not_ready;

        n_compared   = 0;
        n_mismatched = 0;
        n_reset          = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        #3;
        chk_reset_outputs("reset");
        step();
        step();
        n_reset = 1'b1;
        step();
        chk_reset_outputs("post_reset_idle");

        run_op(8'd13, 8'd11, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'hAB, 8'h00, 1'b0);
        run_op(8'd5, 8'd6, 1'b1);
        run_op(8'h00, 8'hFF, 1'b1);

        // Back-to-back with start held high
        bus.multiplicand = 8'd7;
        bus.multiplier   = 8'd9;
        bus.start        = 1'b1;
        step();
        bus.multiplicand = 8'd3;
        bus.multiplier   = 8'd4;
        nd = 0;
        for (int c = 1; c <= 3*PERIOD && nd < 2; c++) begin
            if (bus.done) begin
                done_cyc[nd] = c;
                done_p[nd]   = bus.product;
                nd++;
                if (nd == 2) bus.start = 1'b0;
            end
            if (nd < 2) step();
        end
        bus.start = 1'b0;
        chk("b2b_done_count", nd, 2);
        if (nd == 2) begin
            chk("b2b_first_latency", done_cyc[0], LAT);
            chk("b2b_spacing", done_cyc[1] - done_cyc[0], PERIOD);
            chk("b2b_prod0", done_p[0], 63);
            chk("b2b_prod1", done_p[1], 12);
        end
        step();
        chk("b2b_ready", bus.ready, 1);

        // Abort during the fourth SHIFT
        bus.multiplicand = 8'd200;
        bus.multiplier   = 8'd100;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        sh = 0;
        for (int c = 0; c < 4*N && sh < 4; c++) begin
            if (bus.shift) sh++;
            if (sh < 4) step();
        end
        chk("abort_reached_shift4", sh, 4);
        n_reset = 1'b0;
        #1;
        chk_reset_outputs("abort_async");
        step();
        step();
        n_reset = 1'b1;
        dones = 0;
        not_ready = 0;
        for (int c = 0; c < PERIOD + 6; c++) begin
            step();
            dones     += int'(bus.done);
            not_ready += int'(!bus.ready);
        end
        chk("abort_no_done", dones, 0);
        chk("abort_stays_idle", not_ready, 0);
        chk("abort_product_zero", bus.product, 0);
        run_op(8'd2, 8'd3, 1'b0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) begin
                step();
                chk("gap_ready", bus.ready, 1);
            end
            run_op(N'($urandom), N'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end
endmodule
